// File: rtl/rv_dmem_sram_bridge.sv
// Core data-memory port to rv_sram_driver bridge: in-order request FIFO, one SRAM
// transaction at a time, window filtering and exactly one response pulse per request.
module rv_dmem_sram_bridge #(
    parameter int unsigned    XLEN       = 32,
    parameter int unsigned    FIFO_DEPTH = 2,
    parameter logic [XLEN-1:0] SRAM_BASE = 32'h0000_0000,
    parameter logic [XLEN-1:0] SRAM_SIZE = 32'h0020_0000
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              core_req_i,
    output logic              core_gnt_o,
    input  logic              core_we_i,
    input  logic [XLEN/8-1:0] core_be_i,
    input  logic [XLEN-1:0]   core_addr_i,
    input  logic [XLEN-1:0]   core_wdata_i,
    output logic              core_rvalid_o,
    output logic [XLEN-1:0]   core_rdata_o,
    output logic              core_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned BeW  = XLEN / 8;

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StDrain, StResp} state_e;

    state_e state_q, state_d;

    logic            fifo_we_q    [FIFO_DEPTH];
    logic [BeW-1:0]  fifo_be_q    [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_addr_q  [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_wdata_q [FIFO_DEPTH];
    logic            fifo_err_q   [FIFO_DEPTH];

    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            init_q;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic            push, pop, hold;
    logic [XLEN-1:0] push_off;
    logic            push_err;
    logic            head_we, head_err;
    logic [BeW-1:0]  head_be;
    logic [XLEN-1:0] head_addr, head_wdata, head_off;

    // Grant waits one cycle after reset release and depends only on fullness.
    assign core_gnt_o = init_q & (cnt_q != CntW'(FIFO_DEPTH));
    assign push       = core_req_i & core_gnt_o;
    assign push_off   = core_addr_i - SRAM_BASE;
    assign push_err   = push_off >= SRAM_SIZE;

    assign head_we    = fifo_we_q[rptr_q];
    assign head_be    = fifo_be_q[rptr_q];
    assign head_addr  = fifo_addr_q[rptr_q];
    assign head_wdata = fifo_wdata_q[rptr_q];
    assign head_err   = fifo_err_q[rptr_q];
    assign head_off   = (head_addr - SRAM_BASE) & (SRAM_SIZE - XLEN'(1)) & ~XLEN'(3);

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_we_q[wptr_q]    <= core_we_i;
            fifo_be_q[wptr_q]    <= core_be_i;
            fifo_addr_q[wptr_q]  <= core_addr_i;
            fifo_wdata_q[wptr_q] <= core_wdata_i;
            fifo_err_q[wptr_q]   <= push_err;
        end
    end

    always_comb begin
        wptr_d = push ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d = pop ? rptr_q + PtrW'(1) : rptr_q;
        cnt_d  = cnt_q + CntW'(push) - CntW'(pop);
    end

    always_comb begin
        state_d       = state_q;
        rdata_d       = rdata_q;
        pop           = 1'b0;
        hold          = 1'b0;
        mem_req_o     = 1'b0;
        core_rvalid_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A leftover rvalid run from an aborted transaction blocks issue.
                if (cnt_q != '0) begin
                    if (head_err) begin
                        state_d = StResp;
                    end else if (!mem_rvalid_i) begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                hold      = 1'b1;
                mem_req_o = 1'b1;
                state_d   = StWait;
            end
            StWait: begin
                hold = 1'b1;
                if (mem_rvalid_i) begin
                    rdata_d = mem_rdata_i;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                hold = 1'b1;
                if (mem_rvalid_i) begin
                    rdata_d = mem_rdata_i;
                end else begin
                    state_d = StResp;
                end
            end
            StResp: begin
                core_rvalid_o = 1'b1;
                pop           = 1'b1;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign mem_we_o     = hold & head_we;
    assign mem_be_o     = hold ? head_be : '0;
    assign mem_addr_o   = hold ? head_off : '0;
    assign mem_wdata_o  = hold ? head_wdata : '0;
    assign core_err_o   = core_rvalid_o & head_err;
    assign core_rdata_o = (core_rvalid_o && !head_err && !head_we) ? rdata_q : '0;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= StIdle;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            init_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            init_q  <= 1'b1;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_rv_dmem_sram_bridge.sv
// Randomized bench for rv_dmem_sram_bridge: request-level scoreboard plus a behavioural
// SRAM driver that answers each mem_req_o with a random-length rvalid run.
module tb_rv_dmem_sram_bridge;
    localparam int unsigned  DEPTH = 2;
    localparam logic [31:0]  BASE  = 32'h0000_0000;
    localparam logic [31:0]  SIZE  = 32'h0020_0000;

    logic        clk_i = 1'b0;
    logic        arstn_i = 1'b0;
    logic        core_req_i = 1'b0;
    logic        core_gnt_o;
    logic        core_we_i = 1'b0;
    logic [3:0]  core_be_i = '0;
    logic [31:0] core_addr_i = '0;
    logic [31:0] core_wdata_i = '0;
    logic        core_rvalid_o;
    logic [31:0] core_rdata_o;
    logic        core_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    rv_dmem_sram_bridge #(
        .XLEN       (32),
        .FIFO_DEPTH (DEPTH),
        .SRAM_BASE  (BASE),
        .SRAM_SIZE  (SIZE)
    ) dut (
        .clk_i         (clk_i),
        .arstn_i       (arstn_i),
        .core_req_i    (core_req_i),
        .core_gnt_o    (core_gnt_o),
        .core_we_i     (core_we_i),
        .core_be_i     (core_be_i),
        .core_addr_i   (core_addr_i),
        .core_wdata_i  (core_wdata_i),
        .core_rvalid_o (core_rvalid_o),
        .core_rdata_o  (core_rdata_o),
        .core_err_o    (core_err_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_be_o      (mem_be_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit        we;
        bit [3:0]  be;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit        err;
    } req_t;

    req_t        acc_q[$];
    req_t        issue_q[$];
    logic [31:0] rd_q[$];
    req_t        tx;
    bit          in_tx;
    int          drv_wait, drv_run, force_wait;
    logic [31:0] drv_last;
    int          n_checks, n_errors, cyc, resp_cyc, n_resp;
    bit          resp_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit in_window(input logic [31:0] a);
        longint unsigned x = a;
        return (x >= longint'(BASE)) && (x < longint'(BASE) + longint'(SIZE));
    endfunction

    function automatic logic [31:0] exp_maddr(input logic [31:0] a);
        logic [31:0] off = a - BASE;
        off = off % SIZE;
        return off - (off % 4);
    endfunction

    task automatic check_tx(input string p);
        check_eq({p, "_we"}, mem_we_o, tx.we);
        check_eq({p, "_be"}, mem_be_o, tx.be);
        check_eq({p, "_addr"}, mem_addr_o, exp_maddr(tx.addr));
        check_eq({p, "_wdata"}, mem_wdata_o, tx.wdata);
    endtask

    task automatic monitor();
        req_t        e;
        logic [31:0] d;
        if (core_rvalid_o) begin
            n_resp++;
            resp_cyc = cyc;
            resp_err = core_err_o;
            if (acc_q.size() == 0) begin
                check_eq("stale_resp", core_rvalid_o, 0);
            end else begin
                e = acc_q.pop_front();
                d = '0;
                check_eq("resp_err", core_err_o, e.err);
                if (!e.err) begin
                    if (rd_q.size() == 0) check_eq("resp_before_mem_done", core_rvalid_o, 0);
                    else d = rd_q.pop_front();
                end
                check_eq("resp_rdata", core_rdata_o, (e.err || e.we) ? 32'h0 : d);
            end
        end
        mem_rdata_i = $urandom;
        if (mem_req_o) begin
            check_eq("mem_req_allowed", mem_req_o, (issue_q.size() != 0) && !in_tx);
            if (issue_q.size() != 0 && !in_tx) begin
                tx = issue_q.pop_front();
                check_tx("issue");
                in_tx    = 1'b1;
                drv_wait = (force_wait != 0) ? force_wait : $urandom_range(0, 2);
                drv_run  = $urandom_range(1, 3);
            end
            mem_rvalid_i = 1'b0;
        end else if (in_tx) begin
            check_tx("hold");
            if (drv_wait > 0) begin
                drv_wait--;
                mem_rvalid_i = 1'b0;
            end else if (drv_run > 0) begin
                drv_run--;
                mem_rvalid_i = 1'b1;
                drv_last     = mem_rdata_i;
            end else begin
                mem_rvalid_i = 1'b0;
                rd_q.push_back(drv_last);
                in_tx = 1'b0;
            end
        end else begin
            check_eq("mem_idle_addr", mem_addr_o, 0);
            check_eq("mem_idle_ctl", {mem_we_o, mem_be_o, mem_wdata_o}, 0);
        end
    endtask

    task automatic tick(input bit req, input bit we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata, output bit acc);
        req_t e;
        bit   room;
        @(negedge clk_i);
        cyc++;
        room = acc_q.size() < DEPTH;
        check_eq("gnt", core_gnt_o, room);
        monitor();
        core_req_i   = req;
        core_we_i    = we;
        core_be_i    = be;
        core_addr_i  = addr;
        core_wdata_i = wdata;
        acc = req && room;
        if (acc) begin
            e = '{we, be, addr, wdata, !in_window(addr)};
            acc_q.push_back(e);
            if (!e.err) issue_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) tick(0, 0, 4'h0, 32'h0, 32'h0, a);
    endtask

    task automatic send(input bit we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata);
        bit a = 0;
        int n = 0;
        while (!a && n < 100) begin
            tick(1, we, be, addr, wdata, a);
            n++;
        end
        check_eq("send_accepted", a, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((acc_q.size() != 0 || in_tx) && n < 300) begin
            idle(1);
            n++;
        end
        check_eq("drain_outstanding", acc_q.size(), 0);
        idle(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        bit          a, a1, a2, a3;
        int          r0, c0;
        logic [31:0] addr;
        logic [31:0] edges [5];
        edges = '{32'h0, SIZE - 32'd4, SIZE - 32'd1, SIZE, 32'hFFFF_FFFC};

        repeat (3) @(negedge clk_i);
        check_eq("rst_core", {core_gnt_o, core_rvalid_o, core_rdata_o, core_err_o}, 0);
        check_eq("rst_mem", {mem_req_o, mem_we_o, mem_be_o, mem_wdata_o}, 0);
        check_eq("rst_mem_addr", mem_addr_o, 0);
        arstn_i = 1'b1;
        #1 check_eq("gnt_at_release", core_gnt_o, 0);

        // Read with a multi-beat rvalid run; last beat's data is returned.
        r0 = n_resp;
        send(0, 4'hF, 32'h0000_0010, 32'h0);
        drain();
        check_eq("t1_one_resp", n_resp - r0, 1);

        // Sub-word write at an unaligned address.
        send(1, 4'b0011, 32'h0000_0006, 32'hDEAD_BEEF);
        drain();

        // Back-to-back burst overruns a two-entry FIFO.
        tick(1, 0, 4'hF, 32'h100, 32'h0, a1);
        tick(1, 0, 4'hF, 32'h104, 32'h0, a2);
        tick(1, 0, 4'hF, 32'h108, 32'h0, a3);
        check_eq("t3_gnt_full", core_gnt_o, 0);
        check_eq("t3_first_two", {a1, a2}, 2'b11);
        if (!a3) send(0, 4'hF, 32'h108, 32'h0);
        drain();

        // Out-of-window read responds two cycles after acceptance.
        resp_cyc = -1;
        tick(1, 0, 4'hF, 32'h0020_0000, 32'h0, a);
        c0 = cyc;
        idle(3);
        check_eq("t4_latency", resp_cyc, c0 + 2);
        check_eq("t4_err", resp_err, 1);
        drain();

        // Error request queued behind an SRAM read.
        send(0, 4'hF, 32'h200, 32'h0);
        send(1, 4'hF, 32'h0040_0000, 32'h1234_5678);
        drain();
        check_eq("t5_last_err", resp_err, 1);

        // Randomized traffic including window edges.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0: addr = edges[$urandom_range(0, 4)];
                1: addr = $urandom | 32'h8000_0000;
                default: addr = BASE + $urandom_range(0, SIZE - 1);
            endcase
            tick($urandom_range(0, 2) != 0, 1'($urandom), 4'($urandom_range(1, 15)), addr,
                 $urandom, a);
        end
        drain();

        // Reset in the middle of a transaction waiting for the driver.
        force_wait = 4;
        send(0, 4'hF, 32'h300, 32'h0);
        for (int n = 0; n < 20 && !in_tx; n++) idle(1);
        check_eq("t6_in_wait", in_tx, 1);
        idle(1);
        #2 arstn_i = 1'b0;
        #1;
        check_eq("t6_rst_core", {core_gnt_o, core_rvalid_o, core_rdata_o, core_err_o}, 0);
        check_eq("t6_rst_mem", {mem_req_o, mem_we_o, mem_be_o, mem_wdata_o}, 0);
        check_eq("t6_rst_mem_addr", mem_addr_o, 0);
        acc_q.delete();
        issue_q.delete();
        rd_q.delete();
        in_tx        = 1'b0;
        force_wait   = 0;
        mem_rvalid_i = 1'b0;
        core_req_i   = 1'b0;
        repeat (2) @(negedge clk_i);
        arstn_i = 1'b1;
        #1 check_eq("t6_gnt_at_release", core_gnt_o, 0);
        r0 = n_resp;
        send(0, 4'hF, 32'h40, 32'h0);
        drain();
        idle(5);
        check_eq("t6_one_resp", n_resp - r0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
